// File: rtl/match_cnt_pkg.sv
// Shared types and helpers for the match window counter: FSM state encoding
// and a width-parameterised saturating increment.
package match_cnt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Increment that sticks at 2^cnt_w - 1 instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned cnt_w);
    logic [31:0] max_val;
    max_val = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/result_hold_reg.sv
// Single-entry valid/ready holding register. A load arriving while an
// untaken result is held is discarded and reported on drop for one cycle.
module result_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         drop
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;
  logic         accept;

  // NOTE: every variable written here gets a value on every path first,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    accept  = load && (!valid_q || ready);
    data_d  = accept ? load_data : data_q;
    valid_d = accept || (valid_q && !ready);
    drop_d  = load && valid_q && !ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign drop  = drop_q;

endmodule

// File: rtl/match_window_counter.sv
// Counts high cycles of a match pulse over back-to-back windows of WINDOW
// cycles and publishes each saturated total through a valid/ready register.
module match_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             match_in,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  output logic             busy
);

  import match_cnt_pkg::*;

  localparam int             WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  state_e           state_q;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] acc_sum;
  logic             busy_q;
  logic             win_end;

  always_comb begin
    acc_sum = match_in ? CNT_W'(sat_inc(32'(acc_q), CNT_W)) : acc_q;
    win_end = (state_q == COUNT) && en && (win_q == WIN_LAST);
    acc_d   = '0;
    win_d   = '0;
    // Abort and window end both restart from zero; only a mid-window sample accumulates.
    if (state_q == COUNT && en && win_q != WIN_LAST) begin
      acc_d = acc_sum;
      win_d = win_q + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      win_q   <= '0;
      acc_q   <= '0;
    end else begin
      win_q <= win_d;
      acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          if (!en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  result_hold_reg #(
    .W(CNT_W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (reset),
    .load     (win_end),
    .load_data(acc_sum),
    .ready    (cnt_ready),
    .data     (cnt_data),
    .valid    (cnt_valid),
    .drop     (overrun)
  );

endmodule

// File: doc/match_window_counter.md
# match_window_counter

Downstream consumer of the consecutive-bit pattern detector's `dout_bit` match pulse. Over fixed windows of `WINDOW` clock cycles, it counts how many cycles the match signal was high. Each window total is published through a single-entry valid/ready result register. Back-to-back windows run while `en` is held high, and a result that cannot be delivered is reported on `overrun`.

## Interface
Parameters:
- `WINDOW`, default 16: sampled cycles per window; legal range ≥ 2.
- `CNT_W`, default 8: result width; the count saturates at 2^CNT_W − 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low forces reset immediately, independent of `clk`.
- `en`  in  1  level enable. High starts windows and keeps them running.
- `match_in`  in  1  match pulse, connected to the detector's `dout_bit`.
- `cnt_data`  out  CNT_W  window result. Stable while `cnt_valid` is high.
- `cnt_valid`  out  1  result available.
- `cnt_ready`  in  1  consumer accepts the result.
- `overrun`  out  1  one-cycle pulse: a completed window's result was dropped.
- `busy`  out  1  high while the FSM is in COUNT.

## Operation
- FSM states: IDLE and COUNT.
  - IDLE → COUNT at an edge with `en`=1. `match_in` is not sampled at that edge.
  - COUNT, `en`=1: samples `match_in` every edge, increments the window counter `win` (0..WINDOW−1), and adds 1 to the accumulator `acc` if `match_in`=1.
  - `acc` saturates at 2^CNT_W − 1 and never wraps.
  - COUNT with `en`=0 at an edge: abort. Go to IDLE, clear `acc` and `win`, report nothing. `match_in` at that edge is ignored.
- Window end, the edge where `win`=WINDOW−1 in COUNT with `en`=1:
  - The final value is acc + match_in, saturated.
  - `acc` and `win` clear to 0 and the FSM stays in COUNT, so the next window starts at the following edge with no gap.
- Result register behaviour at a window end:
  - Register empty, or `cnt_valid`=1 and `cnt_ready`=1 at that edge: load the final value and set `cnt_valid`=1.
  - `cnt_valid`=1 and `cnt_ready`=0: keep the old `cnt_data`, drop the new value, and pulse `overrun` for one cycle.
- Handshake:
  - Transfer occurs at an edge with `cnt_valid`=1 and `cnt_ready`=1. `cnt_valid` clears on that edge unless a new result loads on the same edge.
  - `cnt_data` must not change while `cnt_valid`=1 and no transfer occurs.
- An abort does not disturb a pending result. `cnt_valid` and `cnt_data` are held until a transfer.

## Timing
- Reset values, applied asynchronously: state IDLE, `acc`=0, `win`=0, `cnt_data`=0, `cnt_valid`=0, `overrun`=0, `busy`=0.
- `busy` is registered: high from the edge that enters COUNT, low from the edge that leaves it.
- Result latency: `cnt_data` and `cnt_valid` update on the same edge that samples the window's last `match_in`, visible immediately after it.
- Throughput: one result per `WINDOW` cycles.
- `overrun` asserts only on a window-end edge and is high for exactly one cycle.
- Reset asserted mid-window or with a pending result: everything returns to reset values. A partial window is never reported.
- Reset release: the first edge with `reset`=1 is a normal IDLE edge.
- `cnt_ready` may be high while `cnt_valid`=0; it has no effect.

## Structure
- Package `match_cnt_pkg` holds:
  - the state type: IDLE=1'b0, COUNT=1'b1;
  - the saturation helper function, parameterised by CNT_W.
- Sub-module `result_hold_reg` is the single-entry valid/ready register.
  - Inputs: `load`, `load_data`, `ready`.
  - Outputs: `data`, `valid`, `drop`. `drop` feeds `overrun`.
- Top level holds the FSM, `win` counter and `acc`. `win` width is $clog2(WINDOW).

## Test plan
Bench parameters: WINDOW=4, CNT_W=2.
- Reset: drive `reset`=0 with random `en`/`match_in` → all outputs 0 immediately, before any clock edge.
- Basic window: `en`=1, `cnt_ready`=1, `match_in` 1,0,1,1 on the 4 sampled edges → `cnt_data`=3, `cnt_valid` high for exactly 1 cycle after the 4th edge, `busy`=1 throughout.
- Saturation: `match_in`=1 for all 4 edges → `cnt_data`=3 (not 0). Next window `match_in`=0,0,1,0 → `cnt_data`=1, confirming back-to-back windows with no gap.
- Backpressure: `cnt_ready`=0 across two windows with results 2 then 1 → `cnt_data` stays 2 and `overrun` pulses once at the second window end. Then raise `cnt_ready` → one transfer of 2, after which `cnt_valid`=0.
- Abort: `en` dropped after 2 sampled edges with `match_in`=1,1 → no `cnt_valid`, `busy`→0. Re-enable with `match_in` 0,0,0,1 → `cnt_data`=1.
- Reset mid-window with `cnt_valid`=1 → `cnt_valid`, `cnt_data` and `busy` go to 0 asynchronously. After release, a full window 1,1,0,0 → `cnt_data`=2.
